// File: rtl/controle_iluminacao.sv
// Lamp sequencer: button, infrared presence and auto-shutdown pulse drive the lamp and the timer enable.
// Optional long-press manual override is built when MANUAL_OVERRIDE_EN is defined.
module controle_iluminacao #(
  parameter int REARM_T      = 1000,
  parameter int LONG_PRESS_T = 3000
) (
  input  logic clk,
  input  logic rst,
  input  logic botao,
  input  logic infravermelho,
  input  logic C,
  output logic enable,
  output logic L,
  output logic override
);

`ifdef MANUAL_OVERRIDE_EN
  typedef enum logic [1:0] {
    APAGADA  = 2'b00,
    ACESA    = 2'b01,
    BLOQUEIO = 2'b10,
    FORCADA  = 2'b11
  } state_t;
`else
  typedef enum logic [1:0] {
    APAGADA  = 2'b00,
    ACESA    = 2'b01,
    BLOQUEIO = 2'b10
  } state_t;
`endif

  localparam logic [15:0] REARM_LAST = 16'(REARM_T - 1);
  localparam logic [15:0] LONG_LAST  = 16'(LONG_PRESS_T - 1);

  state_t      state, state_n;
  logic [15:0] rc, rc_n;
  logic [15:0] pc, pc_n;
  logic        botao_q;
  logic        edge_evt;
  logic        press;
  logic        long_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= APAGADA;
      rc      <= '0;
      pc      <= '0;
      botao_q <= 1'b1;
    end else begin
      state   <= state_n;
      rc      <= rc_n;
      pc      <= pc_n;
      botao_q <= botao;
    end
  end

  // Button action: short presses act on release when the override is built,
  // otherwise on the rising edge (pc is then held at 0, so the qualifier always passes).
  always_comb begin
`ifdef MANUAL_OVERRIDE_EN
    edge_evt   = ~botao & botao_q;
    long_press = botao & (pc == LONG_LAST);
    if (!botao)
      pc_n = '0;
    else if (pc == 16'(LONG_PRESS_T))
      pc_n = pc;
    else
      pc_n = pc + 16'd1;
`else
    edge_evt   = botao & ~botao_q;
    long_press = 1'b0;
    pc_n       = '0;
`endif
    press = edge_evt & (pc < LONG_LAST);
  end

  always_comb begin
    state_n = state;
    rc_n    = rc;
    case (state)
      APAGADA: begin
        if (press || infravermelho)
          state_n = ACESA;
      end
      ACESA: begin
        if (press) begin
          state_n = APAGADA;
        end else if (C) begin
          state_n = BLOQUEIO;
          rc_n    = '0;
        end
      end
      BLOQUEIO: begin
        if (press) begin
          state_n = ACESA;
          rc_n    = '0;
        end else if (rc == REARM_LAST) begin
          state_n = APAGADA;
          rc_n    = '0;
        end else begin
          rc_n = rc + 16'd1;
        end
      end
`ifdef MANUAL_OVERRIDE_EN
      FORCADA: begin
        if (press)
          state_n = APAGADA;
      end
`endif
      default: begin
        state_n = APAGADA;
        rc_n    = '0;
      end
    endcase
`ifdef MANUAL_OVERRIDE_EN
    // A completed long press overrides everything except an existing override.
    if (long_press && state != FORCADA) begin
      state_n = FORCADA;
      rc_n    = '0;
    end
`endif
  end

  always_comb begin
    L        = 1'b0;
    enable   = 1'b0;
    override = 1'b0;
    case (state)
      ACESA: begin
        L      = 1'b1;
        enable = 1'b1;
      end
`ifdef MANUAL_OVERRIDE_EN
      FORCADA: begin
        L        = 1'b1;
        override = 1'b1;
      end
`endif
      default: begin
        L        = 1'b0;
        enable   = 1'b0;
        override = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_controle_iluminacao.sv
// Self-checking bench for controle_iluminacao: directed corner cases plus a randomized run
// compared every cycle against a behavioural lamp model (follows MANUAL_OVERRIDE_EN).
module tb_controle_iluminacao;

  localparam int RT = 8;
  localparam int LP = 4;

  localparam int OFF    = 0;
  localparam int ON     = 1;
  localparam int BLOCK  = 2;
  localparam int FORCED = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic botao = 1'b1;
  logic infravermelho = 1'b0;
  logic C = 1'b0;
  logic enable, L, override;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  int m_mode = OFF;
  int m_left = 0;
  int m_hold = 0;
  bit m_prev = 1'b1;
  bit m_act, m_lng;
  logic exp_l, exp_en, exp_ov;

  controle_iluminacao #(.REARM_T(RT), .LONG_PRESS_T(LP)) dut (
    .clk(clk),
    .rst(rst),
    .botao(botao),
    .infravermelho(infravermelho),
    .C(C),
    .enable(enable),
    .L(L),
    .override(override)
  );

  always #5 clk = ~clk;

  // Lamp model: a mode, a countdown of remaining re-arm cycles and the length of the current hold.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = OFF;
      m_left = 0;
      m_hold = 0;
      m_prev = 1'b1;
    end else begin
`ifdef MANUAL_OVERRIDE_EN
      m_lng  = botao && (m_hold == LP - 1);
      m_act  = !botao && m_prev && (m_hold < LP - 1);
      m_hold = botao ? ((m_hold < LP) ? m_hold + 1 : LP) : 0;
`else
      m_lng  = 1'b0;
      m_act  = botao && !m_prev;
`endif
      m_prev = botao;
      if (m_lng && m_mode != FORCED) begin
        m_mode = FORCED;
      end else begin
        case (m_mode)
          OFF:    if (m_act || infravermelho) m_mode = ON;
          ON: begin
            if (m_act) m_mode = OFF;
            else if (C) begin
              m_mode = BLOCK;
              m_left = RT;
            end
          end
          BLOCK: begin
            if (m_act) m_mode = ON;
            else if (m_left == 1) m_mode = OFF;
            else m_left = m_left - 1;
          end
          FORCED: if (m_act) m_mode = OFF;
          default: m_mode = OFF;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      exp_l  = (m_mode == ON) || (m_mode == FORCED);
      exp_en = (m_mode == ON);
      exp_ov = (m_mode == FORCED);
      checks = checks + 3;
      if (L !== exp_l) begin
        errors++;
        $display("[TB] FAIL model_L at %0t: got %0b, expected %0b", $time, L, exp_l);
      end
      if (enable !== exp_en) begin
        errors++;
        $display("[TB] FAIL model_enable at %0t: got %0b, expected %0b", $time, enable, exp_en);
      end
      if (override !== exp_ov) begin
        errors++;
        $display("[TB] FAIL model_override at %0t: got %0b, expected %0b", $time, override, exp_ov);
      end
    end
  end

  task automatic applyStimulus(input logic b, input logic ir, input logic c);
    botao = b;
    infravermelho = ir;
    C = c;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, actual, expected);
    end
  endtask

  task automatic pressWith(input logic c);
`ifdef MANUAL_OVERRIDE_EN
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, c);
`else
    applyStimulus(1'b1, 1'b0, c);
    applyStimulus(1'b0, 1'b0, 1'b0);
`endif
  endtask

  // Bring the design to APAGADA with the previous button level low after a reset release.
  task automatic afterReset();
`ifdef MANUAL_OVERRIDE_EN
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("release_after_reset_is_press", L, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("afterreset_off", L, 1'b0);
`else
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("afterreset_off", L, 1'b0);
`endif
  endtask

  task automatic asyncReset(input string name);
    #2 rst = 1'b1;
    #1;
    checkOutput({name, "_L"}, L, 1'b0);
    checkOutput({name, "_enable"}, enable, 1'b0);
    checkOutput({name, "_override"}, override, 1'b0);
    botao = 1'b0;
    infravermelho = 1'b0;
    C = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int run_left;

  initial begin
    $display("[TB] start, REARM_T=%0d LONG_PRESS_T=%0d", RT, LP);
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    checkOutput("reset_L", L, 1'b0);
    checkOutput("reset_enable", enable, 1'b0);
    checkOutput("reset_override", override, 1'b0);
    rst = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("held_through_reset_1", L, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("held_through_reset_2", L, 1'b0);
    asyncReset("reset_again");
    afterReset();

    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("ir_on_L", L, 1'b1);
    checkOutput("ir_on_enable", enable, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stays_on", L, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("c_shutdown_L", L, 1'b0);
    checkOutput("c_shutdown_enable", enable, 1'b0);

    for (int i = 0; i < RT; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("rearm_window_%0d", i), L, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rearm_end_relight", L, 1'b1);

    pressWith(1'b1);
    checkOutput("press_beats_c_L", L, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("relight_no_block", L, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("enter_block", L, 1'b0);
    pressWith(1'b0);
    checkOutput("press_in_block_L", L, 1'b1);
    checkOutput("press_in_block_enable", enable, 1'b1);

    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("block_rc5", L, 1'b0);
    asyncReset("reset_mid_block");
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("ir_after_reset", L, 1'b1);
    asyncReset("reset_mid_acesa");
    afterReset();

    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
`ifdef MANUAL_OVERRIDE_EN
      checkOutput($sformatf("hold_L_%0d", i), L, (i >= LP) ? 1'b1 : 1'b0);
      checkOutput($sformatf("hold_override_%0d", i), override, (i >= LP) ? 1'b1 : 1'b0);
      checkOutput($sformatf("hold_enable_%0d", i), enable, 1'b0);
`else
      checkOutput($sformatf("hold_L_%0d", i), L, 1'b1);
      checkOutput($sformatf("hold_override_%0d", i), override, 1'b0);
`endif
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef MANUAL_OVERRIDE_EN
    checkOutput("long_release_keeps_forcada", override, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("c_ignored_forcada", L, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("ir_ignored_forcada", override, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("short_hold_in_forcada", override, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("short_release_exit_L", L, 1'b0);
    checkOutput("short_release_exit_override", override, 1'b0);
`else
    checkOutput("release_no_toggle", L, 1'b1);
    checkOutput("override_tied_low", override, 1'b0);
`endif

    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        botao = ~botao;
        run_left = $urandom_range(1, 6);
      end
      run_left--;
      if (i == 1500) asyncReset("random_reset");
      applyStimulus(botao, ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/controle_iluminacao.md
# controle_iluminacao

Top-level lamp sequencer for the automatic lighting system. Decides when the lamp is on from the button, the infrared presence sensor and the one-cycle shutdown pulse of the auto-shutdown timer. Drives that timer's enable. After an automatic shutdown it holds a re-arm window so the lamp does not immediately re-trigger.

## Interface

Parameters:
- REARM_T, 1000: cycles after an automatic shutdown during which infrared presence is ignored. Legal range 1..65535.
- LONG_PRESS_T, 3000: button hold length, in cycles, that forces override. Legal range 2..65535. Used only with MANUAL_OVERRIDE_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- botao  in  1  button level: synchronous, debounced, high = pressed.
- infravermelho  in  1  presence level, high = presence.
- C  in  1  auto-shutdown pulse from the timer: one cycle high.
- enable  out  1  timer enable.
- L  out  1  lamp drive.
- override  out  1  high while in FORCADA. Constant 0 without MANUAL_OVERRIDE_EN.

## Operation

- The FSM has states APAGADA, ACESA and BLOQUEIO. FORCADA exists only with MANUAL_OVERRIDE_EN.
- State register, 16-bit rearm counter `rc`, 16-bit press counter `pc` and `botao_q` (previous botao) are all reset asynchronously.
- Reset values:
  - state = APAGADA
  - rc = 0, pc = 0
  - botao_q = 1, so a button held through reset release produces no edge.
- Outputs decode from the state register only; there is no combinational input-to-output path.
  - APAGADA: L=0, enable=0, override=0.
  - ACESA: L=1, enable=1, override=0.
  - BLOQUEIO: L=0, enable=0, override=0.
  - FORCADA: L=1, enable=0, override=1.
- `press` = button action event; its definition depends on the macro (see Configuration).
- APAGADA:
  - press or infravermelho=1 → ACESA.
  - Otherwise stay.
- ACESA:
  - press → APAGADA.
  - Else C=1 → BLOQUEIO with rc <= 0.
  - If press and C arrive in the same cycle, press wins (→ APAGADA).
- BLOQUEIO:
  - infravermelho is ignored; rc increments each cycle.
  - press → ACESA, with rc <= 0.
  - Else rc == REARM_T-1 → APAGADA, with rc <= 0.
- FORCADA:
  - C and infravermelho are ignored.
  - press → APAGADA.
- Illegal or unreachable state encoding → APAGADA on the next edge.
- rst asserted mid-operation forces reset values immediately, regardless of clk.

## Timing

- Every transition takes effect on the clk edge that samples the condition. Outputs change in the following cycle (1-cycle latency).
- Without the macro, a botao rising edge sampled at edge k gives the new L after edge k.
- BLOQUEIO lasts exactly REARM_T cycles when no press occurs.
- Re-entry to ACESA from APAGADA restarts the timer, because enable was low for at least one cycle.
- A C pulse arriving outside ACESA has no effect.

## Configuration

- Macro: MANUAL_OVERRIDE_EN.
- Undefined:
  - press = botao & ~botao_q (rising edge).
  - pc stays 0; FORCADA is unreachable; override is tied to 0.
- Defined:
  - pc counts while botao=1, saturating at LONG_PRESS_T, and clears when botao=0.
  - Long press: the cycle pc reaches LONG_PRESS_T-1 with botao=1 → FORCADA from APAGADA, ACESA or BLOQUEIO.
  - In FORCADA, a long press causes no further transition.
  - press = botao falling edge (~botao & botao_q) with pc < LONG_PRESS_T-1. Short presses therefore act on release.
  - The release that ends a long press is not a press.

## Test plan

- **Infrared turn-on and auto-shutdown.** Reset, then infravermelho=1 for 1 cycle → L=1 and enable=1 one cycle later. Then pulse C → L=0 one cycle after, BLOQUEIO.
- **Re-arm window, REARM_T=8.** After C, hold infravermelho=1 → L stays 0 for 8 cycles. Then APAGADA → ACESA one cycle later, L=1.
- **Simultaneous events.** In ACESA, press and C in the same cycle → APAGADA, L=0, no BLOQUEIO (the next infravermelho=1 relights immediately). In BLOQUEIO, a press → ACESA.
- **Reset corner cases.** Hold botao=1 through rst release → no transition, L=0. Assert rst mid-BLOQUEIO with rc=5 → L=0 and enable=0 at once. After release, infravermelho=1 → ACESA.
- **Override (macro defined, LONG_PRESS_T=4).**
  - Hold botao 6 cycles from APAGADA → FORCADA after the 4th cycle; override=1, L=1, enable=0.
  - A C pulse in FORCADA → no effect.
  - A 2-cycle press → APAGADA on release.
- **Macro undefined.** The same 6-cycle hold toggles on the rising edge only; override stays 0 throughout.
